upc_event_capture: RTL and testbench

UPC_EVENT_CAPTURE -- requirements
Module: upc_event_capture

---
 rtl/upc_trace_pkg.sv | 22 ++
 rtl/upc_trace_fifo.sv | 54 +++++
 rtl/upc_event_capture.sv | 140 ++++++++++++++
 tb/tb_upc_event_capture.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upc_trace_pkg.sv
// Shared types and constants for the kernel event-capture block: FSM states,
// event-mask bit positions and a saturating 16-bit increment helper.
package upc_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fsm_state_e;

    // Event-mask layout, MSB first: {ITER_END, ITER_START, DONE, START}
    localparam int EV_START      = 0;
    localparam int EV_DONE       = 1;
    localparam int EV_ITER_START = 2;
    localparam int EV_ITER_END   = 3;
    localparam int EV_W          = 4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/upc_trace_fifo.sv
// Synchronous record FIFO with full/empty flags; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module upc_trace_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         pop_ok;
    logic         push_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok   = pop & ~empty;
    assign push_ok  = push & (~full | pop_ok);
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/upc_event_capture.sv
// Timestamps kernel START/DONE events (and, with UPC_TRACE_ITER_EN defined,
// pipeline ITER_START/ITER_END events) into a record FIFO with drop accounting.
import upc_trace_pkg::*;

module upc_event_capture #(
    parameter int TS_W  = 32,
    parameter int DEPTH = 16,
    parameter int ST_W  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ap_start,
    input  logic                 ap_done,
    input  logic [ST_W-1:0]      cur_state,
    input  logic [ST_W-1:0]      loop_state,
    input  logic                 stage_block,
    input  logic                 iter_start_enable,
    input  logic                 iter_end_enable,
    input  logic                 finish,
    // rec_valid/rec_ready: a record transfers in any cycle where both are high;
    // rec_data holds steady while rec_valid is high and rec_ready is low.
    output logic                 rec_valid,
    input  logic                 rec_ready,
    output logic [EV_W+TS_W-1:0] rec_data,
    output logic [15:0]          iter_count,
    output logic [15:0]          run_count,
    output logic                 overflow,
    output logic [15:0]          drop_count,
    output fsm_state_e           state_dbg
);

    fsm_state_e      state_q, state_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic [EV_W-1:0] event_mask;
    logic            ev_start, ev_done, ev_iter_start, ev_iter_end;
    logic            fifo_full, fifo_empty;
    logic            rec_push, rec_pop, rec_drop;
    logic            overflow_q, overflow_d;
    logic [15:0]     run_count_q, run_count_d;
    logic [15:0]     drop_count_q, drop_count_d;

    // A done+start pair in RUN is a back-to-back relaunch: both events are logged.
    assign ev_start = ap_start & ((state_q == ST_IDLE) | ((state_q == ST_RUN) & ap_done));
    assign ev_done  = (state_q == ST_RUN) & ap_done;

`ifdef UPC_TRACE_ITER_EN
    logic        iter_hit;
    logic [15:0] iter_count_q, iter_count_d;

    assign iter_hit      = (state_q == ST_RUN) & (cur_state == loop_state) & ~stage_block;
    assign ev_iter_start = iter_hit & iter_start_enable;
    assign ev_iter_end   = iter_hit & iter_end_enable;

    always_comb begin
        iter_count_d = iter_count_q;
        if (ev_start)         iter_count_d = '0;
        else if (ev_iter_end) iter_count_d = sat_inc16(iter_count_q);
    end

    always_ff @(posedge clock) begin
        if (reset) iter_count_q <= '0;
        else       iter_count_q <= iter_count_d;
    end

    assign iter_count = iter_count_q;
`else
    logic unused_iter;
    assign unused_iter   = ^{cur_state, loop_state, stage_block, iter_start_enable, iter_end_enable};
    assign ev_iter_start = 1'b0;
    assign ev_iter_end   = 1'b0;
    assign iter_count    = '0;
`endif

    always_comb begin
        event_mask                = '0;
        event_mask[EV_START]      = ev_start;
        event_mask[EV_DONE]       = ev_done;
        event_mask[EV_ITER_START] = ev_iter_start;
        event_mask[EV_ITER_END]   = ev_iter_end;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ap_start) state_d = ST_RUN;
            ST_RUN:  if (ap_done && !ap_start) state_d = ST_IDLE;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
        if (finish) state_d = ST_HALT;
    end

    assign rec_push  = |event_mask;
    assign rec_valid = ~fifo_empty;
    assign rec_pop   = rec_valid & rec_ready;
    assign rec_drop  = rec_push & fifo_full & ~rec_pop;

    always_comb begin
        ts_d         = ts_q + TS_W'(1);
        overflow_d   = overflow_q | rec_drop;
        drop_count_d = rec_drop ? sat_inc16(drop_count_q) : drop_count_q;
        run_count_d  = ev_done ? sat_inc16(run_count_q) : run_count_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ts_q         <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
            run_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            ts_q         <= ts_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            run_count_q  <= run_count_d;
        end
    end

    upc_trace_fifo #(
        .W     (EV_W + TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rec_push),
        .push_data ({event_mask, ts_q}),
        .pop       (rec_pop),
        .pop_data  (rec_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;
    assign run_count  = run_count_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_upc_event_capture.sv
// Bench for upc_event_capture: directed scenarios plus randomized traffic
// against a queue-based reference model of the capture rules.
import upc_trace_pkg::*;

module tb_upc_event_capture;

  localparam int TS_W  = 32;
  localparam int DEPTH = 16;
  localparam int ST_W  = 4;
  localparam int RW    = EV_W + TS_W;

`ifdef UPC_TRACE_ITER_EN
  localparam bit ITER_ON = 1'b1;
`else
  localparam bit ITER_ON = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic            clock = 1'b0;
  logic            reset;
  logic            ap_start, ap_done, stage_block;
  logic [ST_W-1:0] cur_state, loop_state;
  logic            iter_start_enable, iter_end_enable, finish, rec_ready;
  logic            rec_valid, overflow;
  logic [RW-1:0]   rec_data;
  logic [15:0]     iter_count, run_count, drop_count;
  fsm_state_e      state_dbg;

  always #5 clock = ~clock;

  upc_event_capture #(.TS_W(TS_W), .DEPTH(DEPTH), .ST_W(ST_W)) dut (
    .clock             (clock),
    .reset             (reset),
    .ap_start          (ap_start),
    .ap_done           (ap_done),
    .cur_state         (cur_state),
    .loop_state        (loop_state),
    .stage_block       (stage_block),
    .iter_start_enable (iter_start_enable),
    .iter_end_enable   (iter_end_enable),
    .finish            (finish),
    .rec_valid         (rec_valid),
    .rec_ready         (rec_ready),
    .rec_data          (rec_data),
    .iter_count        (iter_count),
    .run_count         (run_count),
    .overflow          (overflow),
    .drop_count        (drop_count),
    .state_dbg         (state_dbg)
  );

  int vectors = 0;
  int errors  = 0;

  // ---------------- reference model ----------------
  logic [RW-1:0] exp_q[$];
  fsm_state_e    m_state;
  logic [TS_W-1:0] m_ts;
  int            m_iter, m_runs, m_drops;
  bit            m_ovf;

  task automatic model_step();
    logic [3:0] m;
    bit pop;
    if (reset) begin
      exp_q.delete();
      m_state = ST_IDLE;
      m_ts = '0;
      m_iter = 0; m_runs = 0; m_drops = 0; m_ovf = 0;
      return;
    end
    m = 4'b0000;
    if (m_state == ST_IDLE && ap_start) m[0] = 1'b1;
    if (m_state == ST_RUN && ap_done) begin
      m[1] = 1'b1;
      if (ap_start) m[0] = 1'b1;
    end
    if (ITER_ON && m_state == ST_RUN && cur_state == loop_state && !stage_block) begin
      m[2] = iter_start_enable;
      m[3] = iter_end_enable;
    end
    pop = (exp_q.size() != 0) && rec_ready;
    if (pop) void'(exp_q.pop_front());
    if (m != 4'b0000) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({m, m_ts});
      else begin
        m_ovf = 1;
        if (m_drops < 65535) m_drops++;
      end
    end
    if (m[1] && m_runs < 65535) m_runs++;
    if (m[0]) m_iter = 0;
    else if (m[3] && m_iter < 65535) m_iter++;
    if (finish) m_state = ST_HALT;
    else if (m_state == ST_IDLE && ap_start) m_state = ST_RUN;
    else if (m_state == ST_RUN && ap_done && !ap_start) m_state = ST_IDLE;
    m_ts = m_ts + 32'd1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ap_start = 0; ap_done = 0; stage_block = 0;
    cur_state = '0; loop_state = 4'd1;
    iter_start_enable = 0; iter_end_enable = 0;
    finish = 0; rec_ready = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    ap_start = 1; finish = 1; ap_done = 1;
    do_reset();
    idle_inputs();
    vectors++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE); end
    vectors++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL reset_rec_valid: got %0b expected 0", rec_valid); end
    vectors++; if (rec_data !== '0) begin errors++; $display("FAIL reset_rec_data: got %h expected 0", rec_data); end
    vectors++; if (iter_count !== 16'd0 || run_count !== 16'd0 || drop_count !== 16'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL reset_counters: got iter=%0d run=%0d drop=%0d ovf=%0b expected all 0", iter_count, run_count, drop_count, overflow);
    end
  endtask

  task automatic test_start_done();
    do_reset();
    while (m_ts != 32'd10) tick();
    ap_start = 1; tick(); ap_start = 0;
    while (m_ts != 32'd20) tick();
    ap_done = 1; tick(); ap_done = 0;
    vectors++; if (run_count !== 16'd1) begin errors++; $display("FAIL t1_run_count: got %0d expected 1", run_count); end
    vectors++; if (rec_valid !== 1'b1 || rec_data !== {4'b0001, 32'd10}) begin
      errors++; $display("FAIL t1_start_rec: got v=%0b %h expected v=1 %h", rec_valid, rec_data, {4'b0001, 32'd10});
    end
    rec_ready = 1; tick(); rec_ready = 0;
    vectors++; if (rec_valid !== 1'b1 || rec_data !== {4'b0010, 32'd20}) begin
      errors++; $display("FAIL t1_done_rec: got v=%0b %h expected v=1 %h", rec_valid, rec_data, {4'b0010, 32'd20});
    end
    rec_ready = 1; tick(); rec_ready = 0;
    vectors++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL t1_drained: got %0b expected 0", rec_valid); end
    vectors++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL t1_state: got %0d expected %0d", state_dbg, ST_IDLE); end
  endtask

  task automatic test_iter();
    logic [TS_W-1:0] t0;
    int exp_n;
    exp_n = ITER_ON ? 5 : 0;
    do_reset();
    ap_start = 1; tick(); ap_start = 0;
    rec_ready = 1; tick(); rec_ready = 0;
    t0 = m_ts;
    cur_state = 4'd3; loop_state = 4'd3; stage_block = 0;
    iter_start_enable = 1; iter_end_enable = 1;
    for (int i = 0; i < 5; i++) tick();
    idle_inputs();
    vectors++; if (iter_count !== 16'(exp_n)) begin errors++; $display("FAIL t2_iter_count: got %0d expected %0d", iter_count, exp_n); end
    rec_ready = 1;
    for (int i = 0; i < exp_n; i++) begin
      vectors++;
      if (rec_valid !== 1'b1 || rec_data !== {4'b1100, t0 + 32'(i)}) begin
        errors++; $display("FAIL t2_iter_rec%0d: got v=%0b %h expected %h", i, rec_valid, rec_data, {4'b1100, t0 + 32'(i)});
      end
      tick();
    end
    rec_ready = 0;
    vectors++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL t2_no_extra: got %0b expected 0", rec_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    ap_start = 1; tick();
    ap_done = 1;
    for (int i = 0; i < 19; i++) tick();
    idle_inputs();
    vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL t3_overflow: got %0b expected 1", overflow); end
    vectors++; if (drop_count !== 16'd4) begin errors++; $display("FAIL t3_drop_count: got %0d expected 4", drop_count); end
    vectors++; if (state_dbg !== ST_RUN) begin errors++; $display("FAIL t3_state: got %0d expected %0d", state_dbg, ST_RUN); end
    vectors++; if (rec_data !== {4'b0001, 32'd0}) begin errors++; $display("FAIL t3_head: got %h expected %h", rec_data, {4'b0001, 32'd0}); end
  endtask

  task automatic test_full_pop();
    logic [RW-1:0] e;
    // FIFO is full from test_overflow; an event with a simultaneous pop must not drop.
    ap_start = 1; ap_done = 1; rec_ready = 1;
    tick();
    ap_start = 0; ap_done = 0;
    vectors++; if (drop_count !== 16'd4) begin errors++; $display("FAIL t4_no_drop: got %0d expected 4", drop_count); end
    for (int i = 0; i < 16; i++) begin
      e = (i < 15) ? {4'b0011, 32'(i + 1)} : {4'b0011, 32'd20};
      vectors++;
      if (rec_valid !== 1'b1 || rec_data !== e) begin
        errors++; $display("FAIL t4_rec%0d: got v=%0b %h expected %h", i, rec_valid, rec_data, e);
      end
      tick();
    end
    vectors++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL t4_occupancy: got %0b expected 0 after 16 pops", rec_valid); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [TS_W-1:0] t1;
    do_reset();
    ap_start = 1; tick(); ap_start = 0;
    tick();
    t1 = m_ts;
    ap_start = 1; ap_done = 1; tick(); idle_inputs();
    vectors++; if (state_dbg !== ST_RUN) begin errors++; $display("FAIL t5_state: got %0d expected %0d", state_dbg, ST_RUN); end
    vectors++; if (run_count !== 16'd1) begin errors++; $display("FAIL t5_run_count: got %0d expected 1", run_count); end
    rec_ready = 1; tick(); rec_ready = 0;
    vectors++; if (rec_valid !== 1'b1 || rec_data !== {4'b0011, t1}) begin
      errors++; $display("FAIL t5_rec: got v=%0b %h expected %h", rec_valid, rec_data, {4'b0011, t1});
    end
  endtask

  task automatic test_finish();
    logic [TS_W-1:0] t1;
    do_reset();
    finish = 1; tick(); finish = 0;
    ap_start = 1; tick(); ap_start = 0;
    vectors++; if (state_dbg !== ST_HALT) begin errors++; $display("FAIL t6_halt: got %0d expected %0d", state_dbg, ST_HALT); end
    vectors++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL t6_no_start: got %0b expected 0", rec_valid); end
    do_reset();
    tick();
    t1 = m_ts;
    ap_start = 1; finish = 1; tick(); idle_inputs();
    vectors++; if (rec_valid !== 1'b1 || rec_data !== {4'b0001, t1}) begin
      errors++; $display("FAIL t6_finish_cycle_rec: got v=%0b %h expected %h", rec_valid, rec_data, {4'b0001, t1});
    end
    ap_start = 1; ap_done = 1; finish = 1; reset = 1; tick(); reset = 1; tick(); reset = 0; idle_inputs();
    vectors++; if (state_dbg !== ST_IDLE || rec_valid !== 1'b0 || rec_data !== '0 || run_count !== 16'd0
                   || drop_count !== 16'd0 || overflow !== 1'b0 || iter_count !== 16'd0) begin
      errors++; $display("FAIL t6_reset_clear: got st=%0d v=%0b d=%h run=%0d drop=%0d ovf=%0b iter=%0d expected IDLE and zeros",
                         state_dbg, rec_valid, rec_data, run_count, drop_count, overflow, iter_count);
    end
  endtask

  task automatic test_random();
    logic [RW-1:0] e;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      e = (exp_q.size() != 0) ? exp_q[0] : '0;
      vectors++; if (rec_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_valid c%0d: got %0b expected %0b", c, rec_valid, exp_q.size() != 0); end
      vectors++; if (rec_data !== e) begin errors++; $display("FAIL rnd_data c%0d: got %h expected %h", c, rec_data, e); end
      vectors++; if (state_dbg !== m_state) begin errors++; $display("FAIL rnd_state c%0d: got %0d expected %0d", c, state_dbg, m_state); end
      vectors++; if (iter_count !== 16'(m_iter) || run_count !== 16'(m_runs)) begin
        errors++; $display("FAIL rnd_counts c%0d: got iter=%0d run=%0d expected iter=%0d run=%0d", c, iter_count, run_count, m_iter, m_runs);
      end
      vectors++; if (overflow !== m_ovf || drop_count !== 16'(m_drops)) begin
        errors++; $display("FAIL rnd_drop c%0d: got ovf=%0b drop=%0d expected ovf=%0b drop=%0d", c, overflow, drop_count, m_ovf, m_drops);
      end
      ap_start          = ($urandom_range(0, 3) == 0);
      ap_done           = ($urandom_range(0, 4) == 0);
      cur_state         = 4'($urandom_range(0, 2));
      loop_state        = 4'($urandom_range(0, 2));
      stage_block       = ($urandom_range(0, 3) == 0);
      iter_start_enable = ($urandom_range(0, 1) == 0);
      iter_end_enable   = ($urandom_range(0, 1) == 0);
      finish            = ($urandom_range(0, 249) == 0);
      rec_ready         = ((c / 250) % 2 == 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0);
      reset             = (m_state == ST_HALT) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_start_done();
    test_iter();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_finish();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
